// File: rtl/reg_cmd_bridge.sv
// Byte-stream command decoder driving a register file's re/we/addr/wdata port; reads return on a valid/ready stream.
// Optional CMD_TIMEOUT_EN: abandons a write whose data byte does not arrive within TIMEOUT_CYC cycles.
module reg_cmd_bridge #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              reg_we,
  output logic              reg_re,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy,
  output logic              timeout
);

  typedef enum logic [2:0] {IDLE, GET_DATA, WRITE, READ, RESP} state_t;

  state_t state, state_nxt;
  logic   xfer;
  logic   to_hit;

  assign xfer = cmd_valid && cmd_ready;

`ifdef CMD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] to_cnt;

  // Held at zero in IDLE so every entry into GET_DATA starts a fresh count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state != GET_DATA) begin
      to_cnt <= '0;
    end else if (!xfer && !to_hit) begin
      to_cnt <= to_cnt + CNT_W'(1);
    end
  end

  assign to_hit = (state == GET_DATA) && (to_cnt == CNT_W'(TIMEOUT_CYC));
`else
  assign to_hit = 1'b0;
`endif

  assign timeout = to_hit;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    reg_we    = 1'b0;
    reg_re    = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = cmd_data[DATA_W-1] ? GET_DATA : READ;
      end
      GET_DATA: begin
        // An expiring timeout refuses the byte so abort and accept never coincide.
        if (to_hit) begin
          state_nxt = IDLE;
        end else begin
          cmd_ready = 1'b1;
          if (cmd_valid) state_nxt = WRITE;
        end
      end
      WRITE: begin
        reg_we    = 1'b1;
        state_nxt = IDLE;
      end
      READ: begin
        reg_re    = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_addr  <= '0;
      reg_wdata <= '0;
      rsp_data  <= '0;
    end else begin
      if (state == IDLE && xfer)     reg_addr  <= cmd_data[ADDR_W-1:0];
      if (state == GET_DATA && xfer) reg_wdata <= cmd_data;
      if (state == READ)             rsp_data  <= reg_rdata;
    end
  end

endmodule

// File: tb/tb_reg_cmd_bridge.sv
// Directed bench for reg_cmd_bridge with a register-file model and write/read scoreboards.
module tb_reg_cmd_bridge;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
`ifdef CMD_TIMEOUT_EN
  localparam int TO_CYC = 8;
`else
  localparam int TO_CYC = 255;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_data = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [DATA_W-1:0] rsp_data;
  logic              reg_we, reg_re;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic [DATA_W-1:0] reg_rdata;
  logic              busy, timeout;

  logic [DATA_W-1:0] mem [16];
  logic [ADDR_W+DATA_W-1:0] exp_wr [$];
  logic [DATA_W-1:0]        exp_rd [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb reg_rdata = mem[reg_addr];

  reg_cmd_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .reg_we(reg_we), .reg_re(reg_re), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .busy(busy), .timeout(timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-cycle scoreboard, sampled mid-cycle on the falling edge.
  task automatic monitor();
    logic [ADDR_W+DATA_W-1:0] w;
    logic [DATA_W-1:0]        r;
    check("strobe_overlap", {31'd0, reg_we & reg_re}, 32'd0);
    if (reg_we) begin
      if (exp_wr.size() == 0) check("unexpected_we", 32'd1, 32'd0);
      else begin
        w = exp_wr.pop_front();
        check("wr_addr_data", {20'd0, reg_addr, reg_wdata}, {20'd0, w});
      end
      mem[reg_addr] = reg_wdata;
    end
    if (rsp_valid && rsp_ready) begin
      if (exp_rd.size() == 0) check("unexpected_rsp", 32'd1, 32'd0);
      else begin
        r = exp_rd.pop_front();
        check("rsp_data", {24'd0, rsp_data}, {24'd0, r});
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  // Presents a byte and waits for its transfer; leaves cmd_valid asserted.
  task automatic send_byte(input logic [7:0] b, output int waited);
    logic hs;
    hs = 1'b0;
    waited = 0;
    cmd_valid = 1'b1;
    cmd_data  = b;
    while (!hs && waited < 50) begin
      @(negedge clk);
      monitor();
      hs = cmd_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!hs) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int w;
    for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);

    // Reset values
    #12;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rsp", {23'd0, rsp_valid, rsp_data}, 32'd0);
    check("rst_strobes", {30'd0, reg_we, reg_re}, 32'd0);
    check("rst_addr_wdata", {20'd0, reg_addr, reg_wdata}, 32'd0);
    check("rst_busy_to", {30'd0, busy, timeout}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    // Write 0x83 / 0x5A
    exp_wr.push_back({4'd3, 8'h5A});
    send_byte(8'h83, w);
    check("wr_getdata", {30'd0, busy, cmd_ready}, 32'd3);
    send_byte(8'h5A, w);
    cmd_valid = 1'b0;
    check("wr_we_latency", {31'd0, reg_we}, 32'd1);
    check("wr_ready_low", {31'd0, cmd_ready}, 32'd0);
    step();
    check("wr_we_single", {30'd0, reg_we, busy}, 32'd0);

    // Read 0x03 -> register 3 now holds 0x5A
    exp_rd.push_back(8'h5A);
    send_byte(8'h03, w);
    cmd_valid = 1'b0;
    check("rd_re_n1", {30'd0, reg_re, rsp_valid}, 32'd2);
    check("rd_addr", {28'd0, reg_addr}, 32'd3);
    step();
    check("rd_rsp_n2", {23'd0, rsp_valid, rsp_data}, {23'd0, 1'b1, 8'h5A});
    check("rd_re_single", {31'd0, reg_re}, 32'd0);
    step();
    check("rd_done", {30'd0, rsp_valid, cmd_ready}, 32'd1);

    // Response backpressure for 10 cycles, next header pending throughout
    rsp_ready = 1'b0;
    exp_rd.push_back(8'h5A);
    send_byte(8'h03, w);
    cmd_valid = 1'b0;
    step();
    cmd_valid = 1'b1;
    cmd_data  = 8'h02;
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", {22'd0, rsp_valid, cmd_ready, rsp_data}, {22'd0, 2'b10, 8'h5A});
      step();
    end
    rsp_ready = 1'b1;
    exp_rd.push_back(8'hA2);
    step();
    check("bp_release_idle", {30'd0, rsp_valid, cmd_ready}, 32'd1);
    send_byte(8'h02, w);
    cmd_valid = 1'b0;
    check("bp_next_hdr_wait", w, 32'd1);
    check("bp_next_re", {27'd0, reg_re, reg_addr}, {27'd0, 1'b1, 4'd2});
    wait_idle();

    // Back-to-back stream with cmd_valid held high
    exp_wr.push_back({4'd1, 8'h11});
    exp_rd.push_back(8'hA2);
    send_byte(8'h81, w);
    send_byte(8'h11, w);
    send_byte(8'h02, w);
    check("b2b_hdr_wait", w, 32'd2);
    cmd_valid = 1'b0;
    wait_idle();
    step();
    check("b2b_mem1", {24'd0, mem[1]}, 32'h11);

    // Reset in GET_DATA discards the write
    send_byte(8'h84, w);
    cmd_valid = 1'b0;
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", {23'd0, busy, reg_addr, reg_wdata}, 32'd0);
    check("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("mid_after", {30'd0, cmd_ready, busy}, 32'd2);

`ifdef CMD_TIMEOUT_EN
    // Write header with no data byte
    send_byte(8'h85, w);
    cmd_valid = 1'b0;
    w = 0;
    while (!timeout && w < 20) begin
      step();
      w++;
    end
    check("to_latency", w, 32'd8);
    step();
    check("to_pulse_busy", {30'd0, timeout, busy}, 32'd0);
    exp_rd.push_back(8'hA5);
    send_byte(8'h05, w);
    cmd_valid = 1'b0;
    check("to_next_re", {27'd0, reg_re, reg_addr}, {27'd0, 1'b1, 4'd5});
    wait_idle();
`else
    check("to_tied", {31'd0, timeout}, 32'd0);
`endif

    step();
    check("exp_wr_empty", exp_wr.size(), 32'd0);
    check("exp_rd_empty", exp_rd.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_cmd_bridge.md
Name: reg_cmd_bridge

Overview:
Byte-stream command decoder that sits directly upstream of the 16-entry register file and drives its re/we/addr/data_in port.
- Accepts header and data bytes on a valid/ready input stream.
- Issues single-cycle write or read strobes to the register file.
- Returns read data on a valid/ready response stream.
- Used as the host-side access path into the PCIe configuration register block.

Parameters:
ADDR_W, 4, register file address width; header bits [ADDR_W-1:0] carry the address
DATA_W, 8, register data width; equals byte width of command and response streams
TIMEOUT_CYC, 255, cycles to wait for a write data byte before aborting (used only with CMD_TIMEOUT_EN)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command byte valid
cmd_ready  output  1  bridge can accept a command byte
cmd_data  input  DATA_W  command byte (header or write data)
rsp_valid  output  1  read response valid
rsp_ready  input  1  consumer accepts response
rsp_data  output  DATA_W  read data returned
reg_we  output  1  write strobe to register file
reg_re  output  1  read enable to register file
reg_addr  output  ADDR_W  register address
reg_wdata  output  DATA_W  write data to register file
reg_rdata  input  DATA_W  combinational read data from register file
busy  output  1  high in any state other than IDLE
timeout  output  1  one-cycle pulse when a write is aborted (tied 0 without CMD_TIMEOUT_EN)

Behaviour:
- Reset (async, rst_n=0) values:
  - State IDLE.
  - cmd_ready=1; rsp_valid=0; rsp_data=0.
  - reg_we=0; reg_re=0; reg_addr=0; reg_wdata=0.
  - busy=0; timeout=0; timeout counter 0.
- Handshake: a transfer occurs on a rising edge with valid&&ready. Data is sampled only on a transfer.
- Header byte format:
  - bit7: op (1=write, 0=read).
  - bits6:ADDR_W: ignored.
  - bits ADDR_W-1:0: address.
- State IDLE:
  - cmd_ready=1.
  - On header transfer, latch the address into reg_addr.
  - op=1 -> GET_DATA; op=0 -> READ.
- State GET_DATA:
  - cmd_ready=1.
  - On transfer, latch cmd_data into reg_wdata -> WRITE.
- State WRITE:
  - cmd_ready=0; reg_we=1 for exactly this cycle -> IDLE.
- State READ:
  - cmd_ready=0; reg_re=1 for exactly this cycle.
  - reg_rdata is captured into rsp_data on the closing edge -> RESP.
- State RESP:
  - cmd_ready=0; rsp_valid=1.
  - rsp_data is held stable until rsp_ready.
  - On transfer: rsp_valid=0 -> IDLE.
- Latency:
  - Write: data byte accepted at edge M -> reg_we high in cycle M+1.
  - Read: header accepted at edge N -> reg_re high in cycle N+1 -> rsp_valid high from cycle N+2.
- Back-to-back commands:
  - A new header may be accepted in the cycle after WRITE.
  - A new header may be accepted in the cycle after a response transfer.
  - No command overlap: at most one outstanding access.
- reg_addr and reg_wdata hold their last latched values between commands. They are never changed while reg_we or reg_re is high.
- reg_we and reg_re are never high simultaneously.
- Reset mid-command (any state): immediate return to the reset values. A pending write is discarded, and no reg_we is issued after rst_n deasserts.
- rsp_ready held low indefinitely: the bridge stalls in RESP with cmd_ready=0. No command bytes are lost.
- Addresses with no backing register are passed through unchanged; decode is the register file's responsibility.

Optional Feature:
CMD_TIMEOUT_EN
- Defined:
  - In GET_DATA, a counter increments every cycle without a transfer.
  - When the counter reaches TIMEOUT_CYC, the bridge returns to IDLE without writing and pulses timeout for one cycle.
  - The counter clears on entry to GET_DATA.
- Undefined:
  - GET_DATA waits indefinitely.
  - timeout is constant 0 and no counter is built.

Test Plan:
- Write: header 0x83, data 0x5A -> reg_we one cycle, reg_addr=3, reg_wdata=0x5A, one cycle after the data transfer.
- Read: header 0x03 with reg_rdata=0x5A -> reg_re one cycle at N+1; rsp_valid at N+2 with rsp_data=0x5A.
- Response backpressure: rsp_ready=0 for 10 cycles after a read -> rsp_valid and rsp_data held stable, cmd_ready=0. Set rsp_ready=1 -> response transfers; bridge accepts the next header the following cycle.
- Back-to-back: headers 0x81,0x11 then 0x02 streamed with cmd_valid constant 1 -> write addr1 data 0x11, then read addr2. Verify no lost bytes and no overlapping strobes.
- Reset mid-write: rst_n low while in GET_DATA after header 0x84 -> all outputs at reset values; after release, no reg_we occurs and cmd_ready=1.
- CMD_TIMEOUT_EN with TIMEOUT_CYC=8: header 0x85, no data byte -> timeout pulses 8 cycles later, no reg_we, busy=0; next header 0x05 reads normally.
